// File: rtl/alu_writeback_stage.sv
// ALU writeback stage: captures ALU result/flags, commits masked flags to the PSW and writes the
// result to the register file over a req/ack handshake. Define WB_BYPASS_EN to drive fwd_* from the pending write.
module alu_writeback_stage #(
  parameter int WORD    = 16,
  parameter int RF_ADDR = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ex_valid,
  output logic               ex_ready,
  input  logic [WORD-1:0]    alu_res,
  input  logic [3:0]         alu_flags,
  input  logic [3:0]         flag_mask,
  input  logic               wb_en,
  input  logic [RF_ADDR-1:0] dst,
  output logic               rf_we,
  output logic [RF_ADDR-1:0] rf_addr,
  output logic [WORD-1:0]    rf_data,
  input  logic               rf_ack,
  input  logic               psw_ld,
  input  logic [WORD-1:0]    psw_din,
  output logic [WORD-1:0]    psw,
  output logic               alu_cin,
  output logic               fwd_valid,
  output logic [RF_ADDR-1:0] fwd_addr,
  output logic [WORD-1:0]    fwd_data
);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t state, state_nxt;
  logic   xfer;

  assign xfer = ex_valid & ex_ready;

  always_comb begin
    state_nxt = state;
    ex_ready  = 1'b1;
    rf_we     = 1'b0;
    case (state)
      IDLE: begin
        if (xfer) state_nxt = wb_en ? WRITE : IDLE;
      end
      WRITE: begin
        rf_we    = 1'b1;
        // A new op may enter only on the cycle the pending write retires.
        ex_ready = rf_ack;
        if (rf_ack) state_nxt = (xfer && wb_en) ? WRITE : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rf_addr <= '0;
      rf_data <= '0;
    end else begin
      state <= state_nxt;
      if (xfer) begin
        rf_addr <= dst;
        rf_data <= alu_res;
      end
    end
  end

  // A full PSW load overrides any same-cycle flag commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psw <= '0;
    end else if (psw_ld) begin
      psw <= psw_din;
    end else if (xfer) begin
      for (int i = 0; i < 4; i++)
        if (flag_mask[i]) psw[i] <= alu_flags[i];
    end
  end

  assign alu_cin = psw[0];

`ifdef WB_BYPASS_EN
  assign fwd_valid = rf_we;
  assign fwd_addr  = rf_addr;
  assign fwd_data  = rf_data;
`else
  assign fwd_valid = 1'b0;
  assign fwd_addr  = '0;
  assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Scoreboard bench for alu_writeback_stage: expected writes queued at drive time, popped on rf handshake.
module tb_alu_writeback_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [15:0] alu_res;
  logic [3:0]  alu_flags;
  logic [3:0]  flag_mask;
  logic        wb_en;
  logic [2:0]  dst;
  logic        rf_we;
  logic [2:0]  rf_addr;
  logic [15:0] rf_data;
  logic        rf_ack;
  logic        psw_ld;
  logic [15:0] psw_din;
  logic [15:0] psw;
  logic        alu_cin;
  logic        fwd_valid;
  logic [2:0]  fwd_addr;
  logic [15:0] fwd_data;

  alu_writeback_stage #(.WORD(16), .RF_ADDR(3)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .alu_res(alu_res), .alu_flags(alu_flags), .flag_mask(flag_mask), .wb_en(wb_en),
    .dst(dst), .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data), .rf_ack(rf_ack),
    .psw_ld(psw_ld), .psw_din(psw_din), .psw(psw), .alu_cin(alu_cin),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int we_cnt = 0;
  logic watch_ready = 1'b0;
  logic ready_low   = 1'b0;
  logic [18:0] sb_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handshake monitor; inputs only change just after posedge, so negedge sees settled values.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rf_we) we_cnt++;
      if (watch_ready && !ex_ready) ready_low = 1'b1;
      if (rf_we && rf_ack) begin
        if (sb_q.size() == 0) chk("unexpected_write", {13'd0, rf_addr, rf_data}, 32'hFFFF_FFFF);
        else begin
          logic [18:0] e;
          e = sb_q.pop_front();
          chk("wr_addr", {29'd0, rf_addr}, {29'd0, e[18:16]});
          chk("wr_data", {16'd0, rf_data}, {16'd0, e[15:0]});
        end
      end
    end
  end

  // Drive one op; returns just after its capture edge.
  task automatic send(input logic [15:0] res, input logic [3:0] fl, input logic [3:0] mk,
                      input logic wb, input logic [2:0] d);
    int n;
    ex_valid = 1'b1; alu_res = res; alu_flags = fl; flag_mask = mk; wb_en = wb; dst = d;
    if (wb) sb_q.push_back({d, res});
    n = 0;
    forever begin
      @(negedge clk);
      if (ex_ready) break;
      n++;
      if (n > 50) begin
        chk("send_timeout", 32'd0, 32'd1);
        break;
      end
    end
    tick();
    ex_valid = 1'b0;
  endtask

  int base;

  initial begin
    rst_n = 1'b0; ex_valid = 1'b0; alu_res = '0; alu_flags = '0; flag_mask = '0;
    wb_en = 1'b0; dst = '0; rf_ack = 1'b0; psw_ld = 1'b0; psw_din = '0;
    #12;
    chk("rst_psw", {16'd0, psw}, 32'h0);
    chk("rst_we", {31'd0, rf_we}, 32'd0);
    chk("rst_fwd_valid", {31'd0, fwd_valid}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    tick();
    chk("rel_ready", {31'd0, ex_ready}, 32'd1);

    // Single op with a two-cycle write stall
    send(16'h8000, 4'b0100, 4'b1111, 1'b1, 3'd3);
    chk("t2_psw", {28'd0, psw[3:0]}, 32'h4);
    chk("t2_cin", {31'd0, alu_cin}, 32'd0);
    chk("t2_we1", {31'd0, rf_we}, 32'd1);
    chk("t2_ready_stall", {31'd0, ex_ready}, 32'd0);
    tick();
    chk("t2_we2", {31'd0, rf_we}, 32'd1);
    chk("t2_addr_hold", {29'd0, rf_addr}, 32'd3);
    chk("t2_data_hold", {16'd0, rf_data}, 32'h8000);
    rf_ack = 1'b1;
    tick();
    rf_ack = 1'b0;
    chk("t2_idle_we", {31'd0, rf_we}, 32'd0);
    chk("t2_sb_empty", sb_q.size(), 32'd0);

    // Flags-only op with a partial mask
    psw_ld = 1'b1; psw_din = 16'h000F;
    tick();
    psw_ld = 1'b0;
    chk("t3_psw_ld", {16'd0, psw}, 32'h000F);
    chk("t3_cin", {31'd0, alu_cin}, 32'd1);
    base = we_cnt;
    send(16'h7777, 4'b0000, 4'b0010, 1'b0, 3'd4);
    chk("t3_psw", {28'd0, psw[3:0]}, 32'hD);
    chk("t3_we", {31'd0, rf_we}, 32'd0);
    chk("t3_ready", {31'd0, ex_ready}, 32'd1);
    tick();
    chk("t3_no_write", we_cnt - base, 32'd0);

    // Back-to-back with ack tied high
    rf_ack = 1'b1;
    watch_ready = 1'b1;
    base = we_cnt;
    send(16'h0001, 4'b0000, 4'b0000, 1'b1, 3'd1);
    send(16'h0002, 4'b0000, 4'b0000, 1'b1, 3'd2);
    send(16'h0003, 4'b0000, 4'b0000, 1'b1, 3'd3);
    tick();
    tick();
    watch_ready = 1'b0;
    chk("t4_we_cycles", we_cnt - base, 32'd3);
    chk("t4_ready_never_low", {31'd0, ready_low}, 32'd0);
    chk("t4_sb_empty", sb_q.size(), 32'd0);
    rf_ack = 1'b0;

    // PSW load wins over same-cycle flag commit
    psw_ld = 1'b1; psw_din = 16'hA5F0;
    send(16'h0055, 4'b1111, 4'b1111, 1'b1, 3'd6);
    psw_ld = 1'b0;
    chk("t5_psw", {16'd0, psw}, 32'hA5F0);
    chk("t5_we", {31'd0, rf_we}, 32'd1);
    rf_ack = 1'b1;
    tick();
    rf_ack = 1'b0;
    chk("t5_sb_empty", sb_q.size(), 32'd0);
    chk("t5_psw_keep", {16'd0, psw}, 32'hA5F0);

    // Forwarding during a stalled write
    send(16'h1234, 4'b0000, 4'b0000, 1'b1, 3'd5);
    tick();
`ifdef WB_BYPASS_EN
    chk("t6_fwd_valid", {31'd0, fwd_valid}, 32'd1);
    chk("t6_fwd_addr", {29'd0, fwd_addr}, 32'd5);
    chk("t6_fwd_data", {16'd0, fwd_data}, 32'h1234);
`else
    chk("t6_fwd_valid", {31'd0, fwd_valid}, 32'd0);
    chk("t6_fwd_addr", {29'd0, fwd_addr}, 32'd0);
    chk("t6_fwd_data", {16'd0, fwd_data}, 32'h0);
`endif
    rf_ack = 1'b1;
    tick();
    rf_ack = 1'b0;
    chk("t6_sb_empty", sb_q.size(), 32'd0);

    // Asynchronous reset while a write is pending
    send(16'hBEEF, 4'b1111, 4'b1111, 1'b1, 3'd7);
    chk("t1_we_pending", {31'd0, rf_we}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_async_we", {31'd0, rf_we}, 32'd0);
    chk("t1_async_psw", {16'd0, psw}, 32'h0);
    sb_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    tick();
    chk("t1_psw", {16'd0, psw}, 32'h0);
    chk("t1_ready", {31'd0, ex_ready}, 32'd1);
    chk("t1_we_after", {31'd0, rf_we}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
